// File: rtl/ray_frame_scheduler.sv
// Frame-level controller for ray_unit: issues one ray per pixel of a WIDTH x HEIGHT grid,
// buffers in-order results in a credit-protected FIFO and streams them out with sof/eol markers.
module ray_frame_scheduler #(
    parameter int FP_W  = 32,
    parameter int DIM_W = 12,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_W-1:0]    cfg_width,
    input  logic [DIM_W-1:0]    cfg_height,
    input  logic [FP_W-1:0]     cfg_x0,
    input  logic [FP_W-1:0]     cfg_y0,
    input  logic [FP_W-1:0]     cfg_dx,
    input  logic [FP_W-1:0]     cfg_dy,
    input  logic                cfg_sdf_sel,
    output logic                busy,
    output logic                done,
    output logic                overflow_err,
    output logic [FP_W-1:0]     ru_screen_x,
    output logic [FP_W-1:0]     ru_screen_y,
    output logic                ru_valid,
    output logic                ru_sdf_sel,
    input  logic                ru_valid_out,
    input  logic                ru_hit,
    input  logic [3*FP_W-1:0]   ru_point,
    output logic                px_valid,
    input  logic                px_ready,
    output logic [3*FP_W-1:0]   px_point,
    output logic                px_hit,
    output logic                px_sof,
    output logic                px_eol
);
    localparam int PW = 3*FP_W + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
    logic [FP_W-1:0]    x0_q, x0_d, dx_q, dx_d, dy_q, dy_d;
    logic               sel_q, sel_d;
    logic [DIM_W-1:0]   x_q, x_d, y_q, y_d, ox_q, ox_d, oy_q, oy_d;
    logic [FP_W-1:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [CW-1:0]      cred_q, cred_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               zero_pend_q, zero_pend_d, done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;
    logic               ru_valid_q, ru_valid_d, ru_sel_q, ru_sel_d;
    logic [FP_W-1:0]    ru_x_q, ru_x_d, ru_y_q, ru_y_d;
    logic               px_valid_q, px_valid_d;
    logic [PW-1:0]      px_data_q, px_data_d;
    logic [PW-1:0]      mem_q [DEPTH];

    logic               idle_s, issue_s, hs_s, push_s, pop_s, full_s, empty_s;
    logic [CW-1:0]      count_s;
    logic [DIM_W-1:0]   w_s, h_s, xi_s, yi_s;
    logic [FP_W-1:0]    x0_s, cx_s, cy_s, dx_s, dy_s;
    logic               sel_s;

    // On the start cycle the first ray is issued straight from the cfg inputs.
    assign idle_s  = (state_q == S_IDLE);
    assign w_s     = idle_s ? cfg_width   : width_q;
    assign h_s     = idle_s ? cfg_height  : height_q;
    assign x0_s    = idle_s ? cfg_x0      : x0_q;
    assign cx_s    = idle_s ? cfg_x0      : cur_x_q;
    assign cy_s    = idle_s ? cfg_y0      : cur_y_q;
    assign dx_s    = idle_s ? cfg_dx      : dx_q;
    assign dy_s    = idle_s ? cfg_dy      : dy_q;
    assign sel_s   = idle_s ? cfg_sdf_sel : sel_q;
    assign xi_s    = idle_s ? {DIM_W{1'b0}} : x_q;
    assign yi_s    = idle_s ? {DIM_W{1'b0}} : y_q;
    assign hs_s    = px_valid_q && px_ready;
    assign count_s = wr_ptr_q - rd_ptr_q;
    assign full_s  = (count_s == CW'(DEPTH));
    assign empty_s = (count_s == {CW{1'b0}});

    // Frame sequencing, ray issue, credit accounting and output-side bookkeeping.
    always_comb begin
        state_d = state_q;   width_d = width_q;   height_d = height_q;
        x0_d = x0_q;         dx_d = dx_q;         dy_d = dy_q;        sel_d = sel_q;
        x_d = x_q;           y_d = y_q;           ox_d = ox_q;        oy_d = oy_q;
        cur_x_d = cur_x_q;   cur_y_d = cur_y_q;
        ru_valid_d = 1'b0;   ru_x_d = ru_x_q;     ru_y_d = ru_y_q;    ru_sel_d = ru_sel_q;
        zero_pend_d = 1'b0;  done_d = 1'b0;       issue_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d = cfg_width;  height_d = cfg_height;
                    x0_d = cfg_x0;  dx_d = cfg_dx;  dy_d = cfg_dy;  sel_d = cfg_sdf_sel;
                    x_d = {DIM_W{1'b0}};  y_d = {DIM_W{1'b0}};
                    cur_x_d = cfg_x0;  cur_y_d = cfg_y0;
                    ox_d = {DIM_W{1'b0}};  oy_d = {DIM_W{1'b0}};
                    if (cfg_width == {DIM_W{1'b0}} || cfg_height == {DIM_W{1'b0}}) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        issue_s = 1'b1;
                    end
                end else begin
                    done_d = zero_pend_q;
                end
            end
            S_ISSUE: issue_s = (cred_q < CW'(DEPTH));
            S_DRAIN: issue_s = 1'b0;
            default: state_d = S_IDLE;
        endcase

        if (issue_s) begin
            ru_valid_d = 1'b1;  ru_x_d = cx_s;  ru_y_d = cy_s;  ru_sel_d = sel_s;
            if (xi_s == w_s - DIM_W'(1)) begin
                x_d = {DIM_W{1'b0}};  cur_x_d = x0_s;
                y_d = yi_s + DIM_W'(1);  cur_y_d = cy_s + dy_s;
                if (yi_s == h_s - DIM_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end else begin
                x_d = xi_s + DIM_W'(1);  cur_x_d = cx_s + dx_s;
                y_d = yi_s;  cur_y_d = cy_s;
            end
        end else begin
            ru_valid_d = 1'b0;
        end

        if (hs_s && !idle_s) begin
            if (ox_q == width_q - DIM_W'(1)) begin
                ox_d = {DIM_W{1'b0}};
                oy_d = oy_q + DIM_W'(1);
                if (oy_q == height_q - DIM_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    done_d  = 1'b0;
                end
            end else begin
                ox_d = ox_q + DIM_W'(1);
            end
        end else begin
            ox_d = ox_d;
        end

        cred_d = cred_q + CW'(issue_s) - CW'(hs_s && !idle_s);
        busy_d = (state_d != S_IDLE);
    end

    // Result FIFO pointers and the registered output stage.
    always_comb begin
        push_s   = ru_valid_out && !idle_s && !full_s;
        ovf_d    = ovf_q || (ru_valid_out && !idle_s && full_s);
        pop_s    = !empty_s && (!px_valid_q || px_ready);
        wr_ptr_d = wr_ptr_q + CW'(push_s);
        rd_ptr_d = rd_ptr_q + CW'(pop_s);
        if (pop_s) begin
            px_valid_d = 1'b1;
            px_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        end else if (px_ready) begin
            px_valid_d = 1'b0;
            px_data_d  = px_data_q;
        end else begin
            px_valid_d = px_valid_q;
            px_data_d  = px_data_q;
        end
    end

    // FIFO storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {ru_point, ru_hit};
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;  width_q <= '0;  height_q <= '0;
            x0_q <= '0;  dx_q <= '0;  dy_q <= '0;  sel_q <= 1'b0;
            x_q <= '0;  y_q <= '0;  ox_q <= '0;  oy_q <= '0;
            cur_x_q <= '0;  cur_y_q <= '0;  cred_q <= '0;
            wr_ptr_q <= '0;  rd_ptr_q <= '0;
            zero_pend_q <= 1'b0;  done_q <= 1'b0;  busy_q <= 1'b0;  ovf_q <= 1'b0;
            ru_valid_q <= 1'b0;  ru_x_q <= '0;  ru_y_q <= '0;  ru_sel_q <= 1'b0;
            px_valid_q <= 1'b0;  px_data_q <= '0;
        end else begin
            state_q <= state_d;  width_q <= width_d;  height_q <= height_d;
            x0_q <= x0_d;  dx_q <= dx_d;  dy_q <= dy_d;  sel_q <= sel_d;
            x_q <= x_d;  y_q <= y_d;  ox_q <= ox_d;  oy_q <= oy_d;
            cur_x_q <= cur_x_d;  cur_y_q <= cur_y_d;  cred_q <= cred_d;
            wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;
            zero_pend_q <= zero_pend_d;  done_q <= done_d;  busy_q <= busy_d;  ovf_q <= ovf_d;
            ru_valid_q <= ru_valid_d;  ru_x_q <= ru_x_d;  ru_y_q <= ru_y_d;  ru_sel_q <= ru_sel_d;
            px_valid_q <= px_valid_d;  px_data_q <= px_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow_err = ovf_q;
    assign ru_valid     = ru_valid_q;
    assign ru_screen_x  = ru_x_q;
    assign ru_screen_y  = ru_y_q;
    assign ru_sdf_sel   = ru_sel_q;
    assign px_valid     = px_valid_q;
    assign px_point     = px_data_q[PW-1:1];
    assign px_hit       = px_data_q[0];
    // Markers describe the pixel currently held in the output register.
    assign px_sof       = px_valid_q && (ox_q == {DIM_W{1'b0}}) && (oy_q == {DIM_W{1'b0}});
    assign px_eol       = px_valid_q && (ox_q == width_q - DIM_W'(1));
endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Scoreboard bench for ray_frame_scheduler with a fixed-latency ray_unit stand-in.
module tb_ray_frame_scheduler;
    localparam int FP_W  = 32;
    localparam int DIM_W = 12;
    localparam int DEPTH = 16;
    localparam int LAT   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [DIM_W-1:0] cfg_width = '0, cfg_height = '0;
    logic [FP_W-1:0]  cfg_x0 = '0, cfg_y0 = '0, cfg_dx = '0, cfg_dy = '0;
    logic cfg_sdf_sel = 1'b0;
    logic busy, done, overflow_err, ru_valid, ru_sdf_sel, ru_valid_out, ru_hit;
    logic [FP_W-1:0] ru_screen_x, ru_screen_y;
    logic [3*FP_W-1:0] ru_point, px_point;
    logic px_valid, px_hit, px_sof, px_eol;
    logic px_ready = 1'b0;

    always #5 clk = ~clk;

    ray_frame_scheduler #(.FP_W(FP_W), .DIM_W(DIM_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
        .cfg_dx(cfg_dx), .cfg_dy(cfg_dy), .cfg_sdf_sel(cfg_sdf_sel),
        .busy(busy), .done(done), .overflow_err(overflow_err),
        .ru_screen_x(ru_screen_x), .ru_screen_y(ru_screen_y), .ru_valid(ru_valid),
        .ru_sdf_sel(ru_sdf_sel), .ru_valid_out(ru_valid_out), .ru_hit(ru_hit), .ru_point(ru_point),
        .px_valid(px_valid), .px_ready(px_ready), .px_point(px_point), .px_hit(px_hit),
        .px_sof(px_sof), .px_eol(px_eol)
    );

    // ray_unit stand-in: fixed latency, in order, reset by the same event
    logic [LAT-1:0]         m_v, m_s;
    logic [LAT-1:0][31:0]   m_x, m_y;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_v <= '0; m_s <= '0; m_x <= '0; m_y <= '0;
        end else begin
            m_v <= {m_v[LAT-2:0], ru_valid};
            m_s <= {m_s[LAT-2:0], ru_sdf_sel};
            m_x <= {m_x[LAT-2:0], ru_screen_x};
            m_y <= {m_y[LAT-2:0], ru_screen_y};
        end
    end
    assign ru_valid_out = m_v[LAT-1];
    assign ru_point     = {m_x[LAT-1], m_y[LAT-1], m_x[LAT-1] ^ m_y[LAT-1]};
    assign ru_hit       = m_x[LAT-1][15] ^ m_y[LAT-1][15] ^ m_s[LAT-1];

    int n_checks = 0, n_errors = 0;
    logic [64:0] iss_q[$];
    logic [98:0] px_q[$];
    int rv_cnt, pix_cnt, done_cnt, max_inflight, mode;
    logic prev_busy = 1'b0, done_prev_busy = 1'b0, busy_seen, pv_seen;
    logic prev_pv = 1'b0, prev_pr = 1'b0;
    logic [98:0] prev_data = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: drive ready, then observe this cycle's outputs
    task automatic step();
        logic [98:0] cur;
        logic [64:0] ei;
        logic [98:0] ep;
        @(posedge clk); #1;
        case (mode)
            0: px_ready = 1'b1;
            1: px_ready = 1'($urandom_range(0, 1));
            default: px_ready = 1'b0;
        endcase
        if (!rst) begin
            prev_pv = 1'b0;
            prev_busy = 1'b0;
        end else begin
            cur = {px_point, px_hit, px_sof, px_eol};
            if (ru_valid) begin
                rv_cnt++;
                if (iss_q.size() == 0) check("issue_extra", 128'(1), 128'(0));
                else begin
                    ei = iss_q.pop_front();
                    check("issue_coord", 128'({ru_screen_x, ru_screen_y, ru_sdf_sel}), 128'(ei));
                end
            end
            if (prev_pv && !prev_pr) check("stall_hold", 128'({px_valid, cur}), 128'({1'b1, prev_data}));
            if (px_valid && px_ready) begin
                pix_cnt++;
                if (px_q.size() == 0) check("pixel_extra", 128'(1), 128'(0));
                else begin
                    ep = px_q.pop_front();
                    check("pixel_data", 128'(cur), 128'(ep));
                end
            end
            if (busy) busy_seen = 1'b1;
            if (px_valid) pv_seen = 1'b1;
            if (rv_cnt - pix_cnt > max_inflight) max_inflight = rv_cnt - pix_cnt;
            if (done) begin
                done_cnt++;
                done_prev_busy = prev_busy;
                check("busy_at_done", 128'(busy), 128'(0));
            end
            prev_busy = busy; prev_pv = px_valid; prev_pr = px_ready; prev_data = cur;
        end
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] x0, input logic [31:0] y0,
                               input logic [31:0] dx, input logic [31:0] dy, input logic sel);
        logic [31:0] sx, sy;
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
        cfg_x0 = x0; cfg_y0 = y0; cfg_dx = dx; cfg_dy = dy; cfg_sdf_sel = sel;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                sx = x0 + dx * 32'(x);
                sy = y0 + dy * 32'(y);
                iss_q.push_back({sx, sy, sel});
                px_q.push_back({sx, sy, sx ^ sy, sx[15] ^ sy[15] ^ sel, (x == 0 && y == 0), (x == w - 1)});
            end
        end
        rv_cnt = 0; pix_cnt = 0; done_cnt = 0; max_inflight = 0;
        busy_seen = 1'b0; pv_seen = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_width = DIM_W'($urandom); cfg_height = DIM_W'($urandom);
        cfg_x0 = $urandom; cfg_y0 = $urandom; cfg_dx = $urandom; cfg_dy = $urandom;
        cfg_sdf_sel = ~sel;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        check("done_within_budget", 128'(done_cnt != 0), 128'(1));
    endtask

    task automatic end_frame(input int w, input int h);
        repeat (5) step();
        check("done_count", 128'(done_cnt), 128'(1));
        check("pixel_count", 128'(pix_cnt), 128'(w * h));
        check("ray_count", 128'(rv_cnt), 128'(w * h));
        check("issue_left", 128'(iss_q.size()), 128'(0));
        check("pixel_left", 128'(px_q.size()), 128'(0));
    endtask

    initial begin
        mode = 0;
        #12;
        check("reset_ctrl", 128'({busy, done, overflow_err, ru_valid, px_valid, px_sof, px_eol}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // 4x2 frame, Q16.16 unit steps
        start_frame(4, 2, 32'h0, 32'h0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("t1_ru_valid_run", 128'(ru_valid), 128'(1));
            step();
        end
        check("t1_ru_valid_end", 128'(ru_valid), 128'(0));
        wait_done(100);
        check("t1_busy_before_done", 128'(done_prev_busy), 128'(1));
        end_frame(4, 2);

        // 8x8 with downstream stalled: credit limit
        mode = 2;
        start_frame(8, 8, 32'h0003_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 1'b1);
        repeat (99) step();
        check("t2_stalled_rays", 128'(rv_cnt), 128'(DEPTH));
        check("t2_px_waiting", 128'(px_valid), 128'(1));
        mode = 0;
        wait_done(400);
        check("t2_max_inflight", 128'(max_inflight), 128'(DEPTH));
        check("t2_overflow", 128'(overflow_err), 128'(0));
        end_frame(8, 8);

        // zero width
        start_frame(0, 5, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
        check("t3_done_cycle1", 128'(done), 128'(0));
        step();
        check("t3_done_cycle2", 128'(done), 128'(1));
        repeat (8) step();
        check("t3_busy_seen", 128'(busy_seen), 128'(0));
        check("t3_px_seen", 128'(pv_seen), 128'(0));
        end_frame(0, 5);

        // random ready, negative dx
        mode = 1;
        start_frame(3, 3, 32'h0002_0000, 32'h0001_0000, 32'hFFFF_8000, 32'h0000_4000, 1'b1);
        wait_done(300);
        end_frame(3, 3);

        // async reset mid-issue
        mode = 0;
        start_frame(16, 16, 32'h0010_0000, 32'h0020_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (20) step();
        #2; rst = 1'b0; #1;
        check("t5_rst_ctrl", 128'({busy, done, overflow_err, ru_valid, ru_sdf_sel, px_valid, px_hit, px_sof, px_eol}), 128'(0));
        check("t5_rst_coords", 128'({ru_screen_x, ru_screen_y}), 128'(0));
        check("t5_rst_point", 128'(px_point), 128'(0));
        iss_q.delete(); px_q.delete();
        done_cnt = 0;
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();
        check("t5_no_done", 128'(done_cnt), 128'(0));
        start_frame(2, 2, 32'h0000_1000, 32'h0000_2000, 32'h0000_0100, 32'h0000_0200, 1'b1);
        wait_done(100);
        end_frame(2, 2);

        // start during drain is ignored
        mode = 2;
        start_frame(4, 2, 32'h0005_0000, 32'h0006_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (15) step();
        check("t6_in_drain_busy", 128'(busy), 128'(1));
        cfg_width = 12'd3; cfg_height = 12'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 0;
        wait_done(200);
        repeat (30) step();
        end_frame(4, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
- Frame-level controller for `ray_unit`: walks a WIDTH x HEIGHT pixel grid and issues one ray per pixel.
- Generates fixed-point screen coordinates incrementally and drives `ray_unit` inputs from registered outputs.
- Collects in-order `surface_point`/`hit` results into a credit-protected result FIFO.
- Presents results as a valid/ready pixel stream with start-of-frame and end-of-line markers for the shading stage.

Parameters:
- FP_W, 32, width of `fp` scalar; vec3 = 3*FP_W.
- DIM_W, 12, width of frame dimension and pixel counters.
- DEPTH, 16, result FIFO depth = max rays in flight (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin frame; sampled only in IDLE
- cfg_width  in  DIM_W  pixels per line
- cfg_height  in  DIM_W  lines per frame
- cfg_x0  in  FP_W  screen_x of pixel column 0
- cfg_y0  in  FP_W  screen_y of line 0
- cfg_dx  in  FP_W  screen_x step per column (two's complement)
- cfg_dy  in  FP_W  screen_y step per line (two's complement)
- cfg_sdf_sel  in  1  SDF select for the frame
- busy  out  1  high in ISSUE or DRAIN
- done  out  1  one-cycle pulse at frame completion
- overflow_err  out  1  sticky: result arrived with FIFO full
- ru_screen_x  out  FP_W  to `ray_unit.screen_x`
- ru_screen_y  out  FP_W  to `ray_unit.screen_y`
- ru_valid  out  1  to `ray_unit.valid_in`
- ru_sdf_sel  out  1  to `ray_unit.sdf_sel`
- ru_valid_out  in  1  from `ray_unit.valid_out`
- ru_hit  in  1  from `ray_unit.hit`
- ru_point  in  3*FP_W  from `ray_unit.surface_point`
- px_valid  out  1  result available
- px_ready  in  1  downstream accept
- px_point  out  3*FP_W  surface point
- px_hit  out  1  hit flag
- px_sof  out  1  first pixel of frame
- px_eol  out  1  last pixel of a line

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0; `overflow_err` 0.
- Configuration is latched on the start cycle. Cfg inputs are don't-care afterwards.
- `ray_unit` returns results strictly in issue order and has no backpressure. Only the credit counter protects the FIFO.
- Credit counter `cred` (0..DEPTH):
  - +1 per issue, -1 per px handshake (`px_valid && px_ready`).
  - Issue and handshake in the same cycle leave `cred` unchanged.
  - Issue only when `cred < DEPTH`.
- State IDLE:
  - On `start`: latch cfg, x=y=0, cur_x=x0, cur_y=y0, go to ISSUE.
  - If width==0 or height==0: go directly to IDLE again and pulse `done` on the next cycle; no rays, no pixels.
- State ISSUE:
  - Each cycle with credit available: register `ru_valid`=1, `ru_screen_x`=cur_x, `ru_screen_y`=cur_y, `ru_sdf_sel`=latched sel. Otherwise `ru_valid`=0; coordinates hold.
  - First `ru_valid` is asserted the cycle after the start cycle.
  - After issue: if x==width-1 then x=0, cur_x=x0, y+=1, cur_y+=dy; else x+=1, cur_x+=dx.
  - Additions are modulo 2^FP_W, no saturation.
  - Issue of the last pixel (x==width-1, y==height-1) moves to DRAIN.
- State DRAIN:
  - `ru_valid`=0.
  - When the handshake of pixel number width*height occurs, pulse `done` next cycle and go to IDLE.
- Result FIFO:
  - Push on `ru_valid_out` with {point, hit}.
  - If full: drop the result and set `overflow_err`. This is unreachable with the credit scheme.
  - `ru_valid_out` while IDLE is discarded silently.
- Output:
  - `px_valid` rises no earlier than the cycle after the corresponding `ru_valid_out`; registered FIFO read.
  - `px_*` stay stable while `px_valid && !px_ready`.
- Markers, from separate output column/line counters:
  - `px_sof` = out pixel index 0.
  - `px_eol` = out column == width-1.
- `start` in ISSUE/DRAIN is ignored.
- Reset mid-frame:
  - Async clear of everything; the pending frame is abandoned and no `done` is issued.
  - `ray_unit` must be reset with the same event.

Test Plan:
1. 4x2 frame, x0=0, y0=0, dx=dy=0x0001_0000, px_ready=1, ray_unit model latency 5:
   - ru_valid 8 consecutive cycles starting the cycle after start; coords (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) in Q16.16.
   - 8 pixels out with sof on pixel 0 and eol on pixels 3,7.
   - done pulses once; busy drops the same cycle.
2. DEPTH=16, 8x8 frame, px_ready=0 for 100 cycles:
   - Exactly 16 ru_valid pulses, then issue stalls.
   - Releasing ready resumes issue one-for-one with handshakes.
   - All 64 pixels delivered; overflow_err stays 0.
3. width=0, height=5, start:
   - No ru_valid, no px_valid; done pulses on the 2nd cycle after start; busy never rises.
4. Random px_ready (50%) with dx=0xFFFF_8000 (-0.5), 3x3 frame:
   - Column x coordinates x0, x0-0.5, x0-1.0 on each line.
   - px data stable under stall; order matches issue.
5. rst asserted mid-ISSUE of a 16x16 frame:
   - All outputs 0 immediately (async); no done pulse.
   - A new 2x2 start after release completes normally with 4 pixels and sof on the first.
6. start pulsed again during DRAIN:
   - Ignored; exactly one done pulse; pixel count equals width*height.
